// File: rtl/hci_router_order_ctrl.sv
// rtl/hci_router_order_ctrl.sv - order offset sequencer and beat pacer for the channel-reordering HCI router
// Optional build macro HCI_ORDER_CTRL_PERF_EN adds the stall_cnt_o ungranted-request counter.
module hci_router_order_ctrl #(
    parameter int unsigned NB_OUT_CHAN = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_OUTST   = 2,
    localparam int unsigned ORD_W      = $clog2(NB_OUT_CHAN),
    localparam int unsigned OUT_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [ORD_W-1:0] base_order_i,
    input  logic [ORD_W-1:0] step_i,
    input  logic [CNT_W-1:0] beats_per_step_i,
    input  logic [CNT_W-1:0] total_beats_i,
    input  logic             req_i,
    input  logic             wen_i,
    input  logic             gnt_i,
    input  logic             r_valid_i,
    output logic [ORD_W-1:0] order_o,
    output logic             req_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] beat_cnt_o
`ifdef HCI_ORDER_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] OUT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTST);

    state_e             state_q;
    logic [ORD_W-1:0]   order_q, order_d;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic [ORD_W-1:0]   cfg_step_q;
    logic [CNT_W-1:0]   cfg_bps_q;
    logic [CNT_W-1:0]   cfg_total_q;
    logic               done_q;

    logic hs, rd_hs, rsp, last_beat, rot;

    always_comb begin
        req_en_o  = (state_q == RUN) && (beat_cnt_q < cfg_total_q) && (outst_q < OUT_MAX);
        hs        = req_i & req_en_o & gnt_i;
        rd_hs     = hs & ~wen_i;
        // Responses with nothing outstanding are write acks the router let through.
        rsp       = r_valid_i & (outst_q != '0);
        last_beat = (beat_cnt_q == (cfg_total_q - CNT_ONE));
        rot       = hs && (cfg_bps_q != '0) && (step_cnt_q == (cfg_bps_q - CNT_ONE));

        outst_d = outst_q;
        case ({rd_hs, rsp})
            2'b10:   outst_d = outst_q + OUT_ONE;
            2'b01:   outst_d = outst_q - OUT_ONE;
            default: outst_d = outst_q;
        endcase

        step_cnt_d = step_cnt_q;
        if (rot)
            step_cnt_d = '0;
        else if (hs && (cfg_bps_q != '0))
            step_cnt_d = step_cnt_q + CNT_ONE;

        // Wraps modulo NB_OUT_CHAN through ORD_W truncation.
        order_d = rot ? (order_q + cfg_step_q) : order_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= IDLE;
            order_q     <= '0;
            beat_cnt_q  <= '0;
            step_cnt_q  <= '0;
            outst_q     <= '0;
            cfg_step_q  <= '0;
            cfg_bps_q   <= '0;
            cfg_total_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            outst_q <= outst_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cfg_step_q  <= step_i;
                        cfg_bps_q   <= beats_per_step_i;
                        cfg_total_q <= total_beats_i;
                        order_q     <= base_order_i;
                        beat_cnt_q  <= '0;
                        step_cnt_q  <= '0;
                        outst_q     <= '0;
                        if (total_beats_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        beat_cnt_q <= beat_cnt_q + CNT_ONE;
                        step_cnt_q <= step_cnt_d;
                        order_q    <= order_d;
                        if (last_beat)
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outst_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef HCI_ORDER_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == RUN) && req_i && req_en_o && !gnt_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign order_o    = order_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_hci_router_order_ctrl.sv
// tb/tb_hci_router_order_ctrl.sv - directed self-checking bench for hci_router_order_ctrl
module tb_hci_router_order_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, clear_i, start_i;
    logic [1:0]  base_order_i, step_i;
    logic [15:0] beats_per_step_i, total_beats_i;
    logic        req_i, wen_i, gnt_i, r_valid_i;
    logic [1:0]  order_o;
    logic        req_en_o, busy_o, done_o;
    logic [15:0] beat_cnt_o;
`ifdef HCI_ORDER_CTRL_PERF_EN
    logic [15:0] stall_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic rv_auto;

    always #5 clk = ~clk;

    hci_router_order_ctrl #(
        .NB_OUT_CHAN (4),
        .CNT_W       (16),
        .MAX_OUTST   (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .base_order_i     (base_order_i),
        .step_i           (step_i),
        .beats_per_step_i (beats_per_step_i),
        .total_beats_i    (total_beats_i),
        .req_i            (req_i),
        .wen_i            (wen_i),
        .gnt_i            (gnt_i),
        .r_valid_i        (r_valid_i),
        .order_o          (order_o),
        .req_en_o         (req_en_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .beat_cnt_o       (beat_cnt_o)
`ifdef HCI_ORDER_CTRL_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Router model: read responses return one cycle after their grant.
    task automatic tick();
        logic rd_hs_now;
        rd_hs_now = req_i & req_en_o & gnt_i & ~wen_i;
        @(posedge clk);
        #1;
        r_valid_i = rv_auto & rd_hs_now;
    endtask

    task automatic start_xfer(input int b, input int s, input int bps, input int tot);
        base_order_i     = 2'(b);
        step_i           = 2'(s);
        beats_per_step_i = 16'(bps);
        total_beats_i    = 16'(tot);
        start_i          = 1'b1;
        tick();
        start_i          = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!done_o && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(done_o), 1);
    endtask

    int exp_ord1 [8] = '{1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        base_order_i = '0; step_i = '0; beats_per_step_i = '0; total_beats_i = '0;
        req_i = 1'b0; wen_i = 1'b0; gnt_i = 1'b0; r_valid_i = 1'b0; rv_auto = 1'b1;
        tick();
        tick();
        check_eq("rst_order",  32'(order_o), 0);
        check_eq("rst_req_en", 32'(req_en_o), 0);
        check_eq("rst_busy",   32'(busy_o), 0);
        check_eq("rst_done",   32'(done_o), 0);
        check_eq("rst_beat",   32'(beat_cnt_o), 0);
        rst_i = 1'b0;
        tick();

        // Rotating reads: base 1, step 1, two beats per step, eight beats.
        req_i = 1'b1; gnt_i = 1'b1; wen_i = 1'b0;
        start_xfer(1, 1, 2, 8);
        check_eq("t1_busy", 32'(busy_o), 1);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("t1_order_b%0d", k), 32'(order_o), 32'(exp_ord1[k]));
            check_eq($sformatf("t1_beat_b%0d", k), 32'(beat_cnt_o), 32'(k));
            check_eq($sformatf("t1_req_en_b%0d", k), 32'(req_en_o), 1);
            tick();
        end
        check_eq("t1_drain_req_en", 32'(req_en_o), 0);
        check_eq("t1_done_hs1", 32'(done_o), 0);
        tick();
        check_eq("t1_done_hs2", 32'(done_o), 0);
        tick();
        check_eq("t1_done_hs3", 32'(done_o), 1);
        tick();
        check_eq("t1_idle_busy",  32'(busy_o), 0);
        check_eq("t1_idle_done",  32'(done_o), 0);
        check_eq("t1_final_order", 32'(order_o), 1);
        check_eq("t1_final_beat",  32'(beat_cnt_o), 8);

        // Zero-length transfer.
        start_xfer(2, 1, 2, 0);
        check_eq("t2_busy",   32'(busy_o), 1);
        check_eq("t2_done",   32'(done_o), 1);
        check_eq("t2_req_en", 32'(req_en_o), 0);
        check_eq("t2_order",  32'(order_o), 2);
        tick();
        check_eq("t2_idle_busy", 32'(busy_o), 0);
        check_eq("t2_idle_done", 32'(done_o), 0);
        check_eq("t2_idle_req_en", 32'(req_en_o), 0);

        // Grant withheld for five cycles after three beats.
        start_xfer(0, 1, 2, 8);
        tick(); tick(); tick();
        check_eq("t3_pre_beat",  32'(beat_cnt_o), 3);
        check_eq("t3_pre_order", 32'(order_o), 1);
        gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("t3_stall_order%0d", i), 32'(order_o), 1);
            check_eq($sformatf("t3_stall_beat%0d", i), 32'(beat_cnt_o), 3);
        end
`ifdef HCI_ORDER_CTRL_PERF_EN
        check_eq("t3_stall_cnt", 32'(stall_cnt_o), 5);
`endif
        gnt_i = 1'b1;
        wait_done("t3_done", 20);
        tick();
        check_eq("t3_final_order", 32'(order_o), 0);
        check_eq("t3_final_beat",  32'(beat_cnt_o), 8);

        // Outstanding-read limit with responses held back.
        rv_auto = 1'b0;
        start_xfer(0, 1, 0, 8);
        check_eq("t4_req_en0", 32'(req_en_o), 1);
        tick();
        check_eq("t4_req_en1", 32'(req_en_o), 1);
        tick();
        check_eq("t4_req_en_full", 32'(req_en_o), 0);
        check_eq("t4_beat_full",   32'(beat_cnt_o), 2);
        tick();
        check_eq("t4_req_en_hold", 32'(req_en_o), 0);
        check_eq("t4_beat_hold",   32'(beat_cnt_o), 2);
        r_valid_i = 1'b1;
        tick();
        check_eq("t4_req_en_resume", 32'(req_en_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        rv_auto = 1'b1;
        check_eq("t4_clear_busy", 32'(busy_o), 0);

        // Writes without rotation: order constant, no drain wait.
        wen_i = 1'b1;
        start_xfer(2, 3, 0, 6);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("t5_order_b%0d", k), 32'(order_o), 2);
            tick();
        end
        check_eq("t5_done_hs1", 32'(done_o), 0);
        tick();
        check_eq("t5_done_hs2", 32'(done_o), 1);
        check_eq("t5_final_order", 32'(order_o), 2);
        tick();
        wen_i = 1'b0;

        // Soft clear on beat 3, then restart.
        start_xfer(1, 1, 2, 8);
        tick(); tick(); tick();
        check_eq("t6_pre_beat", 32'(beat_cnt_o), 3);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_eq("t6_clr_busy",   32'(busy_o), 0);
        check_eq("t6_clr_done",   32'(done_o), 0);
        check_eq("t6_clr_beat",   32'(beat_cnt_o), 0);
        check_eq("t6_clr_req_en", 32'(req_en_o), 0);
        tick();
        check_eq("t6_no_done", 32'(done_o), 0);
        start_xfer(1, 1, 2, 4);
        check_eq("t6_restart_beat",  32'(beat_cnt_o), 0);
        check_eq("t6_restart_order", 32'(order_o), 1);
        check_eq("t6_restart_busy",  32'(busy_o), 1);
        wait_done("t6_done", 20);
        check_eq("t6_final_beat", 32'(beat_cnt_o), 4);
        check_eq("t6_final_order", 32'(order_o), 3);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
